// File: rtl/alu_arb_pkg.sv
// Shared types, opcode constants and command helper for the two-requester ALU arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [7:0] {
        OP_OR   = 8'd0,
        OP_NAND = 8'd1,
        OP_NOR  = 8'd2,
        OP_AND  = 8'd3,
        OP_ADD  = 8'd4,
        OP_SUB  = 8'd5
    } op_t;

    localparam int unsigned OP_MAX = 5;

    typedef logic req_idx_t;

    // True for any opcode the ALU does not implement.
    function automatic logic cmd_illegal(input logic [31:0] cmd);
        return cmd > 32'(OP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; on a tie the requester not granted last wins.
module rr_arbiter2
    import alu_arb_pkg::*;
(
    input  logic     i_req0_valid,
    input  logic     i_req1_valid,
    input  req_idx_t i_last_grant,
    output logic     o_gnt_valid_c,
    output req_idx_t o_gnt_c
);

    always_comb begin
        o_gnt_valid_c = i_req0_valid | i_req1_valid;
        o_gnt_c       = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            o_gnt_c = ~i_last_grant;
        end else if (i_req1_valid) begin
            o_gnt_c = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin grant and per-requester responses.
// Optional feature: ALU_ARB_CMD_CHECK_EN answers illegal opcodes directly with an error flag.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CMD_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req0_cmd,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,

    output logic [CMD_W-1:0]  alu_cmd,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,

    output logic              busy
);

    state_t            r_state;
    state_t            w_next_state;
    req_idx_t          r_last_grant;
    req_idx_t          r_owner;
    req_idx_t          w_gnt;
    logic              w_gnt_valid;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_illegal;
    logic [CMD_W-1:0]  w_req_cmd;
    logic [DATA_W-1:0] w_req_a;
    logic [DATA_W-1:0] w_req_b;

    logic [CMD_W-1:0]  r_alu_cmd;
    logic [DATA_W-1:0] r_alu_in1;
    logic [DATA_W-1:0] r_alu_in2;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic              r_busy;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req0_valid  (req0_valid),
        .i_req1_valid  (req1_valid),
        .i_last_grant  (r_last_grant),
        .o_gnt_valid_c (w_gnt_valid),
        .o_gnt_c       (w_gnt)
    );

    // Payload of whichever requester holds the grant this cycle.
    assign w_req_cmd = (w_gnt == 1'b1) ? req1_cmd : req0_cmd;
    assign w_req_a   = (w_gnt == 1'b1) ? req1_a   : req0_a;
    assign w_req_b   = (w_gnt == 1'b1) ? req1_b   : req0_b;

    assign w_req_fire = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_rsp_fire = (r_state == ST_RESP) &&
                        ((r_owner == 1'b1) ? rsp1_ready : rsp0_ready);

    assign req0_ready = w_req_fire && (w_gnt == 1'b0);
    assign req1_ready = w_req_fire && (w_gnt == 1'b1);

`ifdef ALU_ARB_CMD_CHECK_EN
    assign w_illegal = cmd_illegal(32'(w_req_cmd));
`else
    assign w_illegal = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; illegal opcodes bypass the ALU settle cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_fire) begin
                    w_next_state = w_illegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (w_rsp_fire) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, ALU operand registers and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_cmd    <= '0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_rsp_data   <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_owner      <= w_gnt;
                        r_last_grant <= w_gnt;
                        if (w_illegal) begin
                            r_rsp_data   <= '0;
                            r_rsp0_valid <= (w_gnt == 1'b0);
                            r_rsp1_valid <= (w_gnt == 1'b1);
                        end else begin
                            r_alu_cmd <= w_req_cmd;
                            r_alu_in1 <= w_req_a;
                            r_alu_in2 <= w_req_b;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_rsp_data   <= alu_out;
                    r_rsp0_valid <= (r_owner == 1'b0);
                    r_rsp1_valid <= (r_owner == 1'b1);
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_alu_cmd    <= '0;
                        r_alu_in1    <= '0;
                        r_alu_in2    <= '0;
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ARB_CMD_CHECK_EN
    logic r_rsp0_err;
    logic r_rsp1_err;

    // Error flags follow the owner's response and drop on its handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0_err <= 1'b0;
            r_rsp1_err <= 1'b0;
        end else if (w_req_fire && w_illegal) begin
            r_rsp0_err <= (w_gnt == 1'b0);
            r_rsp1_err <= (w_gnt == 1'b1);
        end else if (w_rsp_fire) begin
            r_rsp0_err <= 1'b0;
            r_rsp1_err <= 1'b0;
        end
    end

    assign rsp0_err = r_rsp0_err;
    assign rsp1_err = r_rsp1_err;
`else
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    assign alu_cmd    = r_alu_cmd;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign rsp0_data  = r_rsp_data;
    assign rsp1_data  = r_rsp_data;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, round-robin, back-pressure and reset sequences.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_cmd, req0_a, req0_b;
    logic [7:0] req1_cmd, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;
    logic       rsp0_err, rsp1_err;
    logic [7:0] alu_cmd, alu_in1, alu_in2, alu_out;
    logic       busy;

    alu_arbiter #(.DATA_W(8), .CMD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_cmd   (req0_cmd),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_cmd   (req1_cmd),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .alu_cmd    (alu_cmd),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The external ALU the arbiter feeds.
    always_comb begin
        alu_out = 8'h00;
        case (alu_cmd)
            8'd0:    alu_out = alu_in1 | alu_in2;
            8'd1:    alu_out = ~(alu_in1 & alu_in2);
            8'd2:    alu_out = ~(alu_in1 | alu_in2);
            8'd3:    alu_out = alu_in1 & alu_in2;
            8'd4:    alu_out = alu_in1 + alu_in2;
            8'd5:    alu_out = alu_in1 - alu_in2;
            default: alu_out = 8'h00;
        endcase
    end

`ifdef ALU_ARB_CMD_CHECK_EN
    localparam logic ILL_ERR = 1'b1;
    localparam int   ILL_LAT = 1;
`else
    localparam logic ILL_ERR = 1'b0;
    localparam int   ILL_LAT = 2;
`endif

    typedef struct {
        logic       r;
        logic [7:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        logic       err;
        int         lat;
    } vec_t;

    typedef struct {
        logic       r;
        logic [7:0] data;
        logic       err;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event did not occur (t=%0t)", name, $time);
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] c,
                         input logic [7:0] a, input logic [7:0] b);
        if (r) begin
            req1_valid = v; req1_cmd = c; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_cmd = c; req0_a = a; req0_b = b;
        end
    endtask

    function automatic logic rdy(input logic r);
        return r ? req1_ready : req0_ready;
    endfunction

    function automatic logic rv(input logic r);
        return r ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic push_exp(input logic r, input logic [7:0] data, input logic err);
        exp_t e;
        e.r = r; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    // Pop the oldest expected response and compare against the observed one.
    task automatic sb_check(input logic who);
        exp_t e;
        if (sb.size() == 0) begin
            fail_now("scoreboard_underflow");
            return;
        end
        e = sb.pop_front();
        chk("rsp_owner", 32'(who), 32'(e.r));
        chk("rsp_data", 32'(who ? rsp1_data : rsp0_data), 32'(e.data));
        chk("rsp_err", 32'(who ? rsp1_err : rsp0_err), 32'(e.err));
        chk("rsp_other_valid", 32'(rv(~who)), 32'd0);
    endtask

    // Called one step after the accepting edge; lat counts cycles from the accept.
    task automatic wait_rsp(output logic who, output int lat);
        lat = 1;
        while (!(rsp0_valid || rsp1_valid) && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        who = rsp1_valid;
        if (!(rsp0_valid || rsp1_valid)) fail_now("rsp_timeout");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
        chk({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
        chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
        chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
        chk({tag, "_rsp_err"},    32'({rsp1_err, rsp0_err}), 32'd0);
        chk({tag, "_rsp_data"},   32'({rsp1_data, rsp0_data}), 32'd0);
        chk({tag, "_alu_cmd"},    32'(alu_cmd),    32'd0);
        chk({tag, "_alu_in"},     32'({alu_in1, alu_in2}), 32'd0);
    endtask

    // One uncontended transaction; entered and left one step after a rising edge in IDLE.
    task automatic txn(input vec_t v);
        logic who;
        int   lat;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(v.r, 1'b1, v.cmd, v.a, v.b);
        #1;
        chk("vec_req_ready", 32'(rdy(v.r)), 32'd1);
        chk("vec_other_ready", 32'(rdy(~v.r)), 32'd0);
        push_exp(v.r, v.data, v.err);
        @(posedge clk); #1;
        drive(v.r, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("vec_busy", 32'(busy), 32'd1);
        if (v.lat == 2) begin
            chk("vec_alu_cmd", 32'(alu_cmd), 32'(v.cmd));
            chk("vec_alu_in1", 32'(alu_in1), 32'(v.a));
            chk("vec_alu_in2", 32'(alu_in2), 32'(v.b));
        end else begin
            chk("vec_alu_unloaded", 32'({alu_cmd, alu_in1, alu_in2}), 32'd0);
        end
        wait_rsp(who, lat);
        chk("vec_latency", 32'(lat), 32'(v.lat));
        sb_check(who);
        @(posedge clk); #1;
        chk("vec_busy_after", 32'(busy), 32'd0);
        chk("vec_rsp_valid_after", 32'(rv(v.r)), 32'd0);
        chk("vec_alu_cleared", 32'({alu_cmd, alu_in1, alu_in2}), 32'd0);
    endtask

    task automatic rr_test();
        logic who;
        logic g;
        int   lat;
        int   w;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(1'b0, 1'b1, 8'h05, 8'h05, 8'h07);
        drive(1'b1, 1'b1, 8'h01, 8'hF0, 8'h3C);
        #1;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!(req0_ready || req1_ready) && w < 10) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 10) fail_now("rr_no_grant");
            g = req1_ready;
            chk("rr_grant", 32'(g), 32'(k % 2));
            chk("rr_single_ready", 32'(req0_ready & req1_ready), 32'd0);
            push_exp(g, g ? 8'hCF : 8'hFE, 1'b0);
            @(posedge clk); #1;
            wait_rsp(who, lat);
            chk("rr_latency", 32'(lat), 32'd2);
            sb_check(who);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic bp_test();
        logic who;
        int   lat;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h03, 8'hF0, 8'h3C);
        #1;
        chk("bp_req1_ready", 32'(req1_ready), 32'd1);
        push_exp(1'b1, 8'h30, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b0, 1'b1, 8'h00, 8'hA5, 8'h0F);
        wait_rsp(who, lat);
        chk("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 32'(rsp1_valid), 32'd1);
            chk("bp_hold_data", 32'(rsp1_data), 32'h30);
            chk("bp_no_req_ready", 32'(req0_ready | req1_ready), 32'd0);
            chk("bp_rsp0_quiet", 32'(rsp0_valid), 32'd0);
            @(posedge clk); #1;
        end
        rsp1_ready = 1'b1;
        #1;
        sb_check(who);
        @(posedge clk); #1;
        chk("bp_pending_granted", 32'(req0_ready), 32'd1);
        push_exp(1'b0, 8'hAF, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_rsp(who, lat);
        chk("bp_pending_latency", 32'(lat), 32'd2);
        sb_check(who);
        @(posedge clk); #1;
    endtask

    task automatic rst_mid_test();
        logic who;
        int   lat;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(1'b0, 1'b1, 8'h04, 8'h10, 8'h20);
        #1;
        chk("rm_req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("rm_busy_issue", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values("rm_async");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rm_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
            chk("rm_idle", 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b1, 8'h04, 8'h10, 8'h20);
        drive(1'b1, 1'b1, 8'h00, 8'h01, 8'h02);
        #1;
        chk("rm_tie_req0", 32'(req0_ready), 32'd1);
        chk("rm_tie_not_req1", 32'(req1_ready), 32'd0);
        push_exp(1'b0, 8'h30, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_rsp(who, lat);
        chk("rm_latency", 32'(lat), 32'd2);
        sb_check(who);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

        //          r     cmd    a      b      data   err      lat
        vecs[0] = '{1'b0, 8'h04, 8'h7F, 8'h02, 8'h81, 1'b0,    2};
        vecs[1] = '{1'b1, 8'h00, 8'hA5, 8'h0F, 8'hAF, 1'b0,    2};
        vecs[2] = '{1'b0, 8'h01, 8'hF0, 8'h3C, 8'hCF, 1'b0,    2};
        vecs[3] = '{1'b1, 8'h02, 8'h12, 8'h21, 8'hCC, 1'b0,    2};
        vecs[4] = '{1'b0, 8'h03, 8'hF0, 8'h3C, 8'h30, 1'b0,    2};
        vecs[5] = '{1'b1, 8'h04, 8'hFF, 8'h01, 8'h00, 1'b0,    2};
        vecs[6] = '{1'b0, 8'h05, 8'h00, 8'h01, 8'hFF, 1'b0,    2};
        vecs[7] = '{1'b0, 8'h07, 8'hAA, 8'h55, 8'h00, ILL_ERR, ILL_LAT};
        vecs[8] = '{1'b1, 8'h06, 8'h11, 8'h22, 8'h00, ILL_ERR, ILL_LAT};
        vecs[9] = '{1'b1, 8'h05, 8'h05, 8'h07, 8'hFE, 1'b0,    2};

        do_reset();
        check_reset_values("reset");

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i]);
        end

        do_reset();
        rr_test();
        bp_test();
        rst_mid_test();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 8-bit ALU between two independent requesters. Each requester submits `{cmd, a, b}` over a valid/ready handshake. The block grants one requester at a time in round-robin order, drives the ALU operand and command inputs, captures the result, and returns it over a per-requester response handshake. It sits between the ALU and its two client units (for example, the instruction decoder and an address generator).

## Interface
Parameters:
- `DATA_W`, default 8: operand/result width; must match the ALU.
- `CMD_W`, default 8: command width; must match the ALU `cmd` port.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` / `req1_valid` in 1: request offered.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_cmd` / `req1_cmd` in CMD_W: ALU opcode.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in DATA_W: operands (`a` drives ALU `input1`, `b` drives `input2`).
- `rsp0_valid` / `rsp1_valid` out 1: result available.
- `rsp0_ready` / `rsp1_ready` in 1: requester takes the result.
- `rsp0_data` / `rsp1_data` out DATA_W: ALU result.
- `rsp0_err` / `rsp1_err` out 1: illegal command flag (see Configuration).
- `alu_cmd` out CMD_W: to ALU `cmd`.
- `alu_in1`, `alu_in2` out DATA_W: to ALU `input1` / `input2`.
- `alu_out` in DATA_W: from ALU `output`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- ALU opcodes: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD (mod 256, carry dropped), 5 SUB (`a - b`, mod 256). Opcodes 6–255 are illegal; the ALU returns 0x00 for them.
- FSM states are IDLE, ISSUE and RESP.
- **IDLE**
  - Arbitrate: a sole valid requester is granted. If both are valid, grant the one not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` = (state == IDLE) && (grant == N). It is combinational from `valid` and state.
  - Requesters must not wait for ready before raising valid.
  - On handshake: latch cmd/a/b into `alu_cmd`/`alu_in1`/`alu_in2`, record the owner, update `last_grant`, go to ISSUE.
- **ISSUE** (one cycle): the ALU settles. At the clock edge, capture `alu_out` into the result register and go to RESP.
- **RESP**
  - `rspN_valid` = 1 for the owner only. Data and err are held stable until `rspN_ready`.
  - On the response handshake: clear `alu_cmd`/`alu_in1`/`alu_in2` to 0 and return to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- The non-owner's `rsp_valid` is always 0. No response can be lost or duplicated.
- A requester may hold its valid through another requester's transaction. Its request stays pending and wins the next tie.

## Timing
- Reset values:
  - State IDLE; `last_grant` = 1.
  - All `req_ready`, `rsp_valid`, `rsp_err` = 0.
  - `rsp_data`, `alu_cmd`, `alu_in1`, `alu_in2` = 0x00; `busy` = 0.
- Reset mid-operation: the in-flight operation is discarded and no response is issued.
- Latency: request handshake at cycle T, `rsp_valid` high at T+2 (legal command).
- Minimum spacing between accepts is 3 cycles (accept, ISSUE, RESP with ready=1).
- Outputs `alu_*`, `rsp_*` and `busy` are registered. `req_ready` is combinational.

## Configuration
- `ALU_ARB_CMD_CHECK_EN` defined:
  - An accepted command > 5 skips ISSUE and goes directly to RESP.
  - It returns `rsp_data` = 0x00 with `rsp_err` = 1, so latency is T+1.
  - `alu_cmd`/`alu_in1`/`alu_in2` are not loaded for that command.
- Undefined:
  - All commands are issued to the ALU unchanged, with latency T+2.
  - `rsp_err` is tied to 0.

## Structure
- `alu_arb_pkg`:
  - State enum.
  - Opcode constants: OP_OR=0, OP_NAND=1, OP_NOR=2, OP_AND=3, OP_ADD=4, OP_SUB=5.
  - `OP_MAX` = 5.
  - Requester-index type.
- Sub-module `rr_arbiter2`: combinational two-way round-robin grant from `{req1_valid, req0_valid, last_grant}`. The FSM, operand registers and response logic stay in `alu_arbiter`.
- The ALU itself is instantiated outside this block.

## Test plan
- Single request, no contention:
  - Stimulus: requester 0 sends ADD, a=0x7F, b=0x02; `rsp0_ready` held at 1.
  - Expect: ready at T; `alu_in1`=0x7F, `alu_in2`=0x02 at T+1; `rsp0_valid` with data 0x81 at T+2; `busy` low at T+3.
- Tie and round-robin:
  - Stimulus: both requesters continuously valid. Requester 0 sends SUB 0x05,0x07; requester 1 sends NAND 0xF0,0x3C.
  - Expect: grants alternate 0,1,0,1. `rsp0_data`=0xFE and `rsp1_data`=0xCF on every response.
- Response back-pressure:
  - Stimulus: `rsp1_ready` held at 0 for 5 cycles.
  - Expect: `rsp1_valid` and data stay stable; no new `req_ready` until the handshake.
- Reset mid-operation:
  - Stimulus: assert `rst` during ISSUE.
  - Expect: all outputs return to reset values at once; no `rsp_valid` afterwards; the next tie goes to requester 0.
- Illegal command:
  - Stimulus: requester 0 sends cmd 0x07.
  - Expect, with `ALU_ARB_CMD_CHECK_EN`: `rsp_err`=1, data 0x00, `rsp0_valid` at T+1.
  - Expect, without it: `rsp_err`=0, data 0x00 (the ALU's value), `rsp0_valid` at T+2.
